// File: rtl/req_queue4.sv
// req_queue4: four-channel request queue feeding a 4-way grant arbiter.
// Each channel has its own DEPTH-entry FIFO. A channel requests while its
// FIFO is non-empty. The returned grant pops the granted channel's head word
// onto a registered, channel-tagged output.
// Optional build macro: REQQ_OVF_FLAG_EN adds sticky per-channel overflow flags.
//
// Handshake: there is no ready on either side. A push is accepted when
// full_o of that channel is low at the clock edge, and dropped otherwise.
// An output beat is valid for exactly the one cycle out_valid_o is high.
// The consumer always takes it.
module req_queue4 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            push_i,
    input  logic [4*DATA_W-1:0]   push_data_i,
    output logic [3:0]            full_o,
    output logic [3:0]            req_o,
    input  logic [3:0]            gnt_i,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [1:0]            out_id_o,
    output logic [3:0]            ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [AW-1:0]     wr_ptr [4];
    logic [AW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count [4];
    logic [CW-1:0]     count_nxt [4];

    logic [3:0]        push_ok;
    logic [3:0]        cand;
    logic [3:0]        pop_vec;
    logic              pop_hit;
    logic [1:0]        pop_sel;
    logic [DATA_W-1:0] pop_data;

    // Flags decode from the registered count only, so no input reaches them combinationally.
    always_comb begin
        full_o = '0;
        req_o  = '0;
        for (int i = 0; i < 4; i++) begin
            full_o[i] = (count[i] == CW'(DEPTH));
            req_o[i]  = (count[i] != '0);
        end
    end

    // Pick the lowest granted non-empty channel; accept pushes only when not full.
    always_comb begin
        push_ok = push_i & ~full_o;
        cand    = gnt_i & req_o;
        pop_hit = 1'b0;
        pop_sel = 2'd0;
        pop_vec = '0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) begin
                pop_hit = 1'b1;
                pop_sel = 2'(i);
            end
        end
        pop_vec[pop_sel] = pop_hit;
        pop_data = mem[pop_sel][rd_ptr[pop_sel]];
    end

    // Next occupancy per channel; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_nxt[i] = count[i] + CW'(push_ok[i]) - CW'(pop_vec[i]);
        end
    end

    // Payload storage; contents need no reset because pointers and counts gate all reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i]] <= push_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i] <= count_nxt[i];
            end
        end
    end

    // Registered output beat; data and id hold their last value when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
        end else begin
            out_valid_o <= pop_hit;
            if (pop_hit) begin
                out_data_o <= pop_data;
                out_id_o   <= pop_sel;
            end
        end
    end

`ifdef REQQ_OVF_FLAG_EN
    logic [3:0] ovf_q;

    // Sticky flag per channel, set by any push that arrives while the channel is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (push_i & full_o);
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = '0;
`endif

endmodule
